// File: rtl/psram_pkg.sv
// Shared opcodes, FSM state encoding and address helpers for the PSRAM responder.
package psram_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SIO_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ID_W   = 64;

  localparam logic [7:0] OP_RST_EN  = 8'h66;
  localparam logic [7:0] OP_RST     = 8'h99;
  localparam logic [7:0] OP_QPI_EN  = 8'h35;
  localparam logic [7:0] OP_QPI_EX  = 8'hF5;
  localparam logic [7:0] OP_READ_ID = 8'h9F;
  localparam logic [7:0] OP_QREAD   = 8'hEB;
  localparam logic [7:0] OP_QWRITE  = 8'h38;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WAIT,
    RDATA,
    WDATA,
    IDOUT,
    IGNORE
  } state_e;

  // Increment only the in-page bits selected by mask; upper bits stay fixed.
  function automatic logic [ADDR_W-1:0] page_inc(input logic [ADDR_W-1:0] addr,
                                                 input logic [ADDR_W-1:0] mask);
    return (addr & ~mask) | ((addr + ADDR_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/psram_edge_sync.sv
// Two-flop synchronizers for the serial pads plus sclk/ce edge detection.
module psram_edge_sync
  import psram_pkg::*;
(
  input  logic             mem_clk,
  input  logic             reset_n,
  input  logic             psram_sclk,
  input  logic             psram_ce,
  input  logic [SIO_W-1:0] sio_i,
  output logic [SIO_W-1:0] sio_sync,
  output logic             sclk_rise_c,
  output logic             sclk_fall_c,
  output logic             ce_rise_c,
  output logic             ce_fall_c
);

  logic [1:0]       sclk_ff;
  logic [1:0]       ce_ff;
  logic [SIO_W-1:0] sio_ff;
  logic             sclk_prev;
  logic             ce_prev;

  // Synchronizer chains; idle values are ce high, sclk low.
  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_ff   <= 2'b00;
      ce_ff     <= 2'b11;
      sio_ff    <= '0;
      sio_sync  <= '0;
      sclk_prev <= 1'b0;
      ce_prev   <= 1'b1;
    end else begin
      sclk_ff   <= {sclk_ff[0], psram_sclk};
      ce_ff     <= {ce_ff[0], psram_ce};
      sio_ff    <= sio_i;
      sio_sync  <= sio_ff;
      sclk_prev <= sclk_ff[1];
      ce_prev   <= ce_ff[1];
    end
  end

  // Edges come from the newest synchronized sample and the one before it.
  assign sclk_rise_c = sclk_ff[1] & ~sclk_prev;
  assign sclk_fall_c = ~sclk_ff[1] & sclk_prev;
  assign ce_rise_c   = ce_ff[1] & ~ce_prev;
  assign ce_fall_c   = ~ce_ff[1] & ce_prev;

endmodule

// File: rtl/psram_responder.sv
// PSRAM target model: SPI/QPI command decode, ID read, quad read/write to a byte store.
module psram_responder
  import psram_pkg::*;
#(
  parameter int unsigned    WAIT_CYCLES = 6,
  parameter logic [ID_W-1:0] ID_VALUE   = 64'h0D5D_5A5A_0000_0000,
  parameter int unsigned    PAGE_BITS   = 10
) (
  input  logic              mem_clk,
  input  logic              reset_n,
  input  logic              psram_sclk,
  input  logic              psram_ce,
  input  logic [SIO_W-1:0]  sio_i,
  output logic [SIO_W-1:0]  sio_o,
  output logic [SIO_W-1:0]  sio_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              qpi_mode
);

  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((64'd1 << PAGE_BITS) - 64'd1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [SIO_W-1:0] sio_sync;
  logic             sclk_rise_c;
  logic             sclk_fall_c;
  logic             ce_rise_c;
  logic             ce_fall_c;

  psram_edge_sync u_sync (
    .mem_clk     (mem_clk),
    .reset_n     (reset_n),
    .psram_sclk  (psram_sclk),
    .psram_ce    (psram_ce),
    .sio_i       (sio_i),
    .sio_sync    (sio_sync),
    .sclk_rise_c (sclk_rise_c),
    .sclk_fall_c (sclk_fall_c),
    .ce_rise_c   (ce_rise_c),
    .ce_fall_c   (ce_fall_c)
  );

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] sh, sh_nxt;
  logic [7:0]        op, op_nxt;
  logic              half, half_nxt;
  logic [SIO_W-1:0]  nib, nib_nxt;
  logic [DATA_W-1:0] rbyte, rbyte_nxt;
  logic              re_d, re_d_nxt;
  logic [ID_W-1:0]   id_sh, id_sh_nxt;
  logic              armed, armed_nxt;
  logic              pend, pend_nxt;
  logic              pend_val, pend_val_nxt;
  logic              qpi_nxt;
  logic [SIO_W-1:0]  sio_o_nxt, sio_oe_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              we_nxt, re_nxt;
  logic [ADDR_W-1:0] shift_in;
  logic [CNT_W-1:0]  cmd_last, addr_last;

  // State and datapath registers.
  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      op        <= '0;
      half      <= 1'b0;
      nib       <= '0;
      rbyte     <= '0;
      re_d      <= 1'b0;
      id_sh     <= '0;
      armed     <= 1'b0;
      pend      <= 1'b0;
      pend_val  <= 1'b0;
      qpi_mode  <= 1'b0;
      sio_o     <= '0;
      sio_oe    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sh        <= sh_nxt;
      op        <= op_nxt;
      half      <= half_nxt;
      nib       <= nib_nxt;
      rbyte     <= rbyte_nxt;
      re_d      <= re_d_nxt;
      id_sh     <= id_sh_nxt;
      armed     <= armed_nxt;
      pend      <= pend_nxt;
      pend_val  <= pend_val_nxt;
      qpi_mode  <= qpi_nxt;
      sio_o     <= sio_o_nxt;
      sio_oe    <= sio_oe_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_we    <= we_nxt;
      mem_re    <= re_nxt;
    end
  end

  // Next-state, transfer sequencing and pad/memory outputs.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sh_nxt       = sh;
    op_nxt       = op;
    half_nxt     = half;
    nib_nxt      = nib;
    rbyte_nxt    = rbyte;
    re_d_nxt     = mem_re;
    id_sh_nxt    = id_sh;
    armed_nxt    = armed;
    pend_nxt     = pend;
    pend_val_nxt = pend_val;
    qpi_nxt      = qpi_mode;
    sio_o_nxt    = sio_o;
    sio_oe_nxt   = sio_oe;
    addr_nxt     = mem_addr;
    wdata_nxt    = mem_wdata;
    we_nxt       = 1'b0;
    re_nxt       = 1'b0;

    shift_in  = qpi_mode ? {sh[ADDR_W-5:0], sio_sync} : {sh[ADDR_W-2:0], sio_sync[0]};
    cmd_last  = qpi_mode ? CNT_W'(1) : CNT_W'(7);
    addr_last = qpi_mode ? CNT_W'(5) : CNT_W'(23);

    // Read data arrives one cycle after the strobe.
    if (re_d) begin
      rbyte_nxt = mem_rdata;
    end
    // Advance the write pointer the cycle after each write strobe.
    if (mem_we) begin
      addr_nxt = page_inc(mem_addr, PAGE_MASK);
    end

    if (ce_rise_c) begin
      state_nxt  = IDLE;
      sio_oe_nxt = '0;
      sio_o_nxt  = '0;
      if (pend) begin
        qpi_nxt  = pend_val;
        pend_nxt = 1'b0;
      end
    end else if (ce_fall_c) begin
      state_nxt  = CMD;
      cnt_nxt    = '0;
      sio_oe_nxt = '0;
    end else begin
      case (state)
        CMD: begin
          if (sclk_rise_c) begin
            sh_nxt  = shift_in;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == cmd_last) begin
              cnt_nxt   = '0;
              op_nxt    = shift_in[7:0];
              armed_nxt = 1'b0;
              state_nxt = IGNORE;
              case (shift_in[7:0])
                OP_RST_EN: armed_nxt = 1'b1;
                OP_RST: begin
                  if (armed) begin
                    pend_nxt     = 1'b1;
                    pend_val_nxt = 1'b0;
                  end
                end
                OP_QPI_EN: begin
                  pend_nxt     = 1'b1;
                  pend_val_nxt = 1'b1;
                end
                OP_QPI_EX: begin
                  pend_nxt     = 1'b1;
                  pend_val_nxt = 1'b0;
                end
                OP_READ_ID: begin
                  if (!qpi_mode) state_nxt = ADDR;
                end
                OP_QREAD, OP_QWRITE: begin
                  if (qpi_mode) state_nxt = ADDR;
                end
                default: ;
              endcase
            end
          end
        end
        ADDR: begin
          if (sclk_rise_c) begin
            sh_nxt  = shift_in;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == addr_last) begin
              cnt_nxt  = '0;
              half_nxt = 1'b0;
              if (op == OP_READ_ID) begin
                state_nxt = IDOUT;
                id_sh_nxt = ID_VALUE;
              end else begin
                addr_nxt = shift_in;
                if (op == OP_QREAD) begin
                  re_nxt = 1'b1;
                  if (WAIT_CYCLES == 0) state_nxt = RDATA;
                  else                  state_nxt = WAIT;
                end else begin
                  state_nxt = WDATA;
                end
              end
            end
          end
        end
        WAIT: begin
          if (sclk_rise_c) begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == WAIT_LAST) begin
              cnt_nxt   = '0;
              state_nxt = RDATA;
            end
          end
        end
        RDATA: begin
          if (sclk_fall_c) begin
            sio_oe_nxt = '1;
            if (!half) begin
              // Present the high nibble, keep the low one, prefetch the next byte.
              sio_o_nxt = rbyte[7:4];
              nib_nxt   = rbyte[3:0];
              re_nxt    = 1'b1;
              addr_nxt  = page_inc(mem_addr, PAGE_MASK);
              half_nxt  = 1'b1;
            end else begin
              sio_o_nxt = nib;
              half_nxt  = 1'b0;
            end
          end
        end
        WDATA: begin
          if (sclk_rise_c) begin
            if (!half) begin
              nib_nxt  = sio_sync;
              half_nxt = 1'b1;
            end else begin
              wdata_nxt = {nib, sio_sync};
              we_nxt    = 1'b1;
              half_nxt  = 1'b0;
            end
          end
        end
        IDOUT: begin
          if (sclk_fall_c) begin
            sio_oe_nxt = 4'b0010;
            sio_o_nxt  = {2'b00, id_sh[ID_W-1], 1'b0};
            id_sh_nxt  = {id_sh[ID_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_responder.sv
// Directed bench for psram_responder: ID read, mode switching, quad write/read, wrap, abort.
module tb_psram_responder;

  localparam int          HP     = 80;
  localparam logic [63:0] EXP_ID = 64'h0D5D_5A5A_0000_0000;

  logic        mem_clk;
  logic        reset_n;
  logic        psram_sclk;
  logic        psram_ce;
  logic [3:0]  sio_i;
  logic [3:0]  sio_o;
  logic [3:0]  sio_oe;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        qpi_mode;

  int checks;
  int errors;
  int we_cnt;
  logic [23:0] we_addr_log [0:255];
  logic [7:0]  we_data_log [0:255];
  logic [7:0]  bmem [0:1023];

  psram_responder dut (
    .mem_clk    (mem_clk),
    .reset_n    (reset_n),
    .psram_sclk (psram_sclk),
    .psram_ce   (psram_ce),
    .sio_i      (sio_i),
    .sio_o      (sio_o),
    .sio_oe     (sio_oe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .qpi_mode   (qpi_mode)
  );

  initial begin
    mem_clk = 1'b0;
    forever #5 mem_clk = ~mem_clk;
  end

  // Backing store write side plus a log of every write strobe.
  initial we_cnt = 0;
  always @(negedge mem_clk) begin
    if (mem_we) begin
      if (we_cnt < 256) begin
        we_addr_log[we_cnt] <= mem_addr;
        we_data_log[we_cnt] <= mem_wdata;
      end
      bmem[mem_addr[9:0]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  // Backing store read side: data valid one cycle after the strobe.
  always @(posedge mem_clk) begin
    if (mem_re) mem_rdata <= bmem[mem_addr[9:0]];
  end

  task automatic sclk_cycle(input logic [3:0] d);
    sio_i = d;
    #(HP/2);
    psram_sclk = 1'b1;
    #(HP);
    psram_sclk = 1'b0;
    #(HP/2);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sclk_cycle({3'b000, b[i]});
  endtask

  task automatic quad_byte(input logic [7:0] b);
    sclk_cycle(b[7:4]);
    sclk_cycle(b[3:0]);
  endtask

  task automatic ce_low();
    psram_ce = 1'b0;
    #(HP);
  endtask

  task automatic ce_high();
    #(HP);
    psram_ce = 1'b1;
    #(2*HP);
  endtask

  task automatic read_id_txn(output logic [63:0] got, output logic [3:0] oe_first);
    ce_low();
    spi_byte(8'h9F);
    repeat (3) spi_byte(8'h00);
    got = '0;
    oe_first = sio_oe;
    for (int i = 0; i < 64; i++) begin
      got = {got[62:0], sio_o[1]};
      if (i < 63) sclk_cycle(4'h0);
    end
    ce_high();
  endtask

  task automatic test_reset();
    if (qpi_mode !== 1'b0) begin errors++; $display("FAIL reset_qpi got %b want 0", qpi_mode); end
    checks++;
    if (sio_oe !== 4'h0) begin errors++; $display("FAIL reset_oe got %h want 0", sio_oe); end
    checks++;
    if (sio_o !== 4'h0) begin errors++; $display("FAIL reset_sio_o got %h want 0", sio_o); end
    checks++;
    if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {mem_we, mem_re}); end
    checks++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin errors++; $display("FAIL reset_mem got %h want 0", {mem_addr, mem_wdata}); end
    checks++;
  endtask

  task automatic test_read_id();
    logic [63:0] got;
    logic [3:0]  oe;
    ce_low(); spi_byte(8'h66); ce_high();
    ce_low(); spi_byte(8'h99); ce_high();
    read_id_txn(got, oe);
    if (oe !== 4'b0010) begin errors++; $display("FAIL id_oe got %h want 2", oe); end
    checks++;
    if (got !== EXP_ID) begin errors++; $display("FAIL id_value got %h want %h", got, EXP_ID); end
    checks++;
    if (qpi_mode !== 1'b0) begin errors++; $display("FAIL id_qpi got %b want 0", qpi_mode); end
    checks++;
    if (sio_oe !== 4'h0) begin errors++; $display("FAIL id_oe_after_ce got %h want 0", sio_oe); end
    checks++;
  endtask

  task automatic test_mode_switch();
    ce_low();
    spi_byte(8'h35);
    #(HP);
    if (qpi_mode !== 1'b0) begin errors++; $display("FAIL qpi_before_ce got %b want 0", qpi_mode); end
    checks++;
    ce_high();
    if (qpi_mode !== 1'b1) begin errors++; $display("FAIL qpi_enter got %b want 1", qpi_mode); end
    checks++;
    ce_low(); quad_byte(8'hF5); ce_high();
    if (qpi_mode !== 1'b0) begin errors++; $display("FAIL qpi_exit got %b want 0", qpi_mode); end
    checks++;
    ce_low(); spi_byte(8'h35); ce_high();
    if (qpi_mode !== 1'b1) begin errors++; $display("FAIL qpi_reenter got %b want 1", qpi_mode); end
    checks++;
  endtask

  task automatic test_write_burst();
    int base;
    base = we_cnt;
    ce_low();
    quad_byte(8'h38);
    quad_byte(8'h00); quad_byte(8'h00); quad_byte(8'h40);
    for (int i = 0; i < 64; i++) quad_byte(8'(i));
    ce_high();
    if (we_cnt - base !== 64) begin errors++; $display("FAIL wr_count got %0d want 64", we_cnt - base); end
    checks++;
    for (int i = 0; i < 64; i++) begin
      if (we_addr_log[base+i] !== 24'(32'h40 + i) || we_data_log[base+i] !== 8'(i)) begin
        errors++;
        $display("FAIL wr_beat%0d got %h/%h want %h/%h", i, we_addr_log[base+i], we_data_log[base+i],
                 24'(32'h40 + i), 8'(i));
      end
      checks++;
    end
  endtask

  task automatic test_read_burst();
    logic [63:0] got;
    ce_low();
    quad_byte(8'hEB);
    quad_byte(8'h00); quad_byte(8'h00); quad_byte(8'h40);
    repeat (5) sclk_cycle(4'h0);
    if (sio_oe !== 4'h0) begin errors++; $display("FAIL rd_oe_6th_fall got %h want 0", sio_oe); end
    checks++;
    sclk_cycle(4'h0);
    if (sio_oe !== 4'hF) begin errors++; $display("FAIL rd_oe_7th_fall got %h want f", sio_oe); end
    checks++;
    got = '0;
    for (int i = 0; i < 16; i++) begin
      got = {got[59:0], sio_o};
      if (i < 15) sclk_cycle(4'h0);
    end
    if (got !== 64'h0001_0203_0405_0607) begin errors++; $display("FAIL rd_nibbles got %h want 0001020304050607", got); end
    checks++;
    ce_high();
    if (sio_oe !== 4'h0) begin errors++; $display("FAIL rd_oe_after_ce got %h want 0", sio_oe); end
    checks++;
  endtask

  task automatic test_page_wrap();
    int base;
    logic [23:0] exp_a [4];
    exp_a = '{24'h0003FE, 24'h0003FF, 24'h000000, 24'h000001};
    base = we_cnt;
    ce_low();
    quad_byte(8'h38);
    quad_byte(8'h00); quad_byte(8'h03); quad_byte(8'hFE);
    for (int i = 0; i < 4; i++) quad_byte(8'(8'hA0 + i));
    ce_high();
    if (we_cnt - base !== 4) begin errors++; $display("FAIL wrap_count got %0d want 4", we_cnt - base); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      if (we_addr_log[base+i] !== exp_a[i] || we_data_log[base+i] !== 8'(8'hA0 + i)) begin
        errors++;
        $display("FAIL wrap_beat%0d got %h/%h want %h/%h", i, we_addr_log[base+i], we_data_log[base+i],
                 exp_a[i], 8'(8'hA0 + i));
      end
      checks++;
    end
  endtask

  task automatic test_abort_and_reset();
    int base;
    logic [63:0] got;
    logic [3:0]  oe;
    base = we_cnt;
    ce_low();
    quad_byte(8'h38);
    quad_byte(8'h00); quad_byte(8'h01); quad_byte(8'h00);
    sclk_cycle(4'h5); sclk_cycle(4'hA); sclk_cycle(4'hC);
    ce_high();
    if (we_cnt - base !== 1) begin errors++; $display("FAIL abort_count got %0d want 1", we_cnt - base); end
    checks++;
    if (we_addr_log[base] !== 24'h000100 || we_data_log[base] !== 8'h5A) begin
      errors++; $display("FAIL abort_beat got %h/%h want 000100/5a", we_addr_log[base], we_data_log[base]);
    end
    checks++;
    ce_low();
    quad_byte(8'hEB);
    quad_byte(8'h00); quad_byte(8'h00); quad_byte(8'h00);
    repeat (7) sclk_cycle(4'h0);
    if (sio_oe !== 4'hF) begin errors++; $display("FAIL abort_in_rdata got %h want f", sio_oe); end
    checks++;
    reset_n = 1'b0;
    repeat (2) @(negedge mem_clk);
    test_reset();
    psram_ce = 1'b1;
    repeat (4) @(negedge mem_clk);
    reset_n = 1'b1;
    repeat (4) @(negedge mem_clk);
    if (we_cnt - base !== 1) begin errors++; $display("FAIL reset_no_we got %0d want 1", we_cnt - base); end
    checks++;
    read_id_txn(got, oe);
    if (got !== EXP_ID) begin errors++; $display("FAIL id_after_reset got %h want %h", got, EXP_ID); end
    checks++;
    if (oe !== 4'b0010) begin errors++; $display("FAIL id_oe_after_reset got %h want 2", oe); end
    checks++;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    psram_ce   = 1'b1;
    psram_sclk = 1'b0;
    sio_i      = 4'h0;
    repeat (3) @(negedge mem_clk);
    test_reset();
    reset_n = 1'b1;
    repeat (3) @(negedge mem_clk);
    test_reset();
    test_read_id();
    test_mode_switch();
    test_write_burst();
    test_read_burst();
    test_page_wrap();
    test_abort_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
